output_queue_requester: RTL and testbench

- Requester side of the output-port priority arbiter in the shared-cache switch.
- Holds one small descriptor queue per input port (packet base address, length, priority) and presents the arbiter with packed `request_signals` / `priorities` vectors.
- Consumes the arbiter's `grant` / `grant_vld`: pops the granted port's head descriptor and issues a burst of shared-cache read commands for that packet, one packet at a time.

---
 rtl/output_queue_requester_pkg.sv | 41 ++++
 rtl/output_queue_requester_if.sv | 34 +++
 rtl/output_queue_requester_desc_fifo.sv | 46 ++++
 rtl/output_queue_requester.sv | 97 +++++++++
 tb/tb_output_queue_requester.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/output_queue_requester_pkg.sv
// Shared constants, state encoding and descriptor packing for output_queue_requester.
// Port and priority counts come from `PORT_NUB_TOTAL / `PRI_NUM_TOTAL (generate_parameter.vh defaults below).
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 16
`endif
`ifndef PRI_NUM_TOTAL
`define PRI_NUM_TOTAL 8
`endif

package output_queue_requester_pkg;

  localparam int PORT_NUB_TOTAL = `PORT_NUB_TOTAL;
  localparam int PRI_NUM_TOTAL  = `PRI_NUM_TOTAL;
  localparam int QUEUE_DEPTH    = 8;
  localparam int ADDR_WIDTH     = 10;
  localparam int LEN_WIDTH      = 6;
  localparam int PORT_WIDTH     = $clog2(PORT_NUB_TOTAL);
  localparam int PRI_WIDTH_SIG  = $clog2(PRI_NUM_TOTAL);
  localparam int PRI_WIDTH      = PORT_NUB_TOTAL * PRI_WIDTH_SIG;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  // Descriptor layout, MSB to LSB: addr | len | pri
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    addr;
    logic [LEN_WIDTH-1:0]     len;
    logic [PRI_WIDTH_SIG-1:0] pri;
  } desc_t;

  function automatic desc_t pack_desc(input logic [ADDR_WIDTH-1:0]    addr,
                                      input logic [LEN_WIDTH-1:0]     len,
                                      input logic [PRI_WIDTH_SIG-1:0] pri);
    desc_t d;
    d.addr = addr;
    d.len  = len;
    d.pri  = pri;
    return d;
  endfunction

endpackage

// File: rtl/output_queue_requester_if.sv
// Bus bundle of output_queue_requester: descriptor enqueue, arbiter request/grant, cache read commands.
// Handshakes: enq transfers on a clk edge with enq_vld && enq_rdy; a read beat transfers on a clk
// edge with rd_vld && rd_rdy; once rd_vld is high, rd_addr/rd_last/rd_port hold until that transfer.
interface output_queue_requester_if;
  import output_queue_requester_pkg::*;

  logic                      enq_vld;
  logic [PORT_WIDTH-1:0]     enq_port;
  logic [ADDR_WIDTH-1:0]     enq_addr;
  logic [LEN_WIDTH-1:0]      enq_len;
  logic [PRI_WIDTH_SIG-1:0]  enq_pri;
  logic                      enq_rdy;
  logic [PORT_NUB_TOTAL-1:0] request_signals;
  logic [PRI_WIDTH-1:0]      priorities;
  logic [PORT_WIDTH-1:0]     grant;
  logic                      grant_vld;
  logic                      rd_vld;
  logic                      rd_rdy;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [PORT_WIDTH-1:0]     rd_port;
  logic                      rd_last;
  logic                      busy;

  modport master (
    input  enq_vld, enq_port, enq_addr, enq_len, enq_pri, grant, grant_vld, rd_rdy,
    output enq_rdy, request_signals, priorities, rd_vld, rd_addr, rd_port, rd_last, busy
  );

  modport slave (
    output enq_vld, enq_port, enq_addr, enq_len, enq_pri, grant, grant_vld, rd_rdy,
    input  enq_rdy, request_signals, priorities, rd_vld, rd_addr, rd_port, rd_last, busy
  );

endinterface

// File: rtl/output_queue_requester_desc_fifo.sv
// oqr_desc_fifo: per-port descriptor FIFO with registered head; pointers carry one wrap bit
// so full and empty are distinguished without a separate counter.
module oqr_desc_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 19
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; the head is only consumed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/output_queue_requester.sv
// Requester side of the output-port arbiter: per-port descriptor queues, request/priority vectors,
// and one-packet-at-a-time cache read bursts. Optional OQR_BUSY_MASK_EN hides requests during a burst.
module output_queue_requester
  import output_queue_requester_pkg::*;
(
  input logic                     clk,
  input logic                     reset_n,
  output_queue_requester_if.master bus
);

  logic [PORT_NUB_TOTAL-1:0] q_empty;
  logic [PORT_NUB_TOTAL-1:0] q_full;
  logic [PORT_NUB_TOTAL-1:0] q_push;
  logic [PORT_NUB_TOTAL-1:0] q_pop;
  logic [PORT_NUB_TOTAL-1:0] req_raw;
  logic [PORT_NUB_TOTAL-1:0] req_vis;
  logic [PRI_WIDTH-1:0]      prio_vec;
  desc_t                     q_head [PORT_NUB_TOTAL];
  desc_t                     enq_desc;
  desc_t                     grant_desc;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat;
  logic [PORT_WIDTH-1:0] port_q;
  logic                  grant_fire;
  logic                  beat_fire;
  logic                  last_beat;

  assign enq_desc   = pack_desc(bus.enq_addr, bus.enq_len, bus.enq_pri);
  assign req_raw    = ~q_empty;
  assign grant_desc = q_head[bus.grant];
  assign grant_fire = (state == ST_IDLE) && bus.grant_vld && req_raw[bus.grant];
  assign beat_fire  = (state == ST_XFER) && bus.rd_rdy;
  assign last_beat  = (beat == len_q);

  genvar i;
  generate
    for (i = 0; i < PORT_NUB_TOTAL; i++) begin : g_q
      assign q_push[i] = bus.enq_vld && (bus.enq_port == PORT_WIDTH'(i)) && !q_full[i];
      assign q_pop[i]  = grant_fire && (bus.grant == PORT_WIDTH'(i));

      oqr_desc_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .W     ($bits(desc_t))
      ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (q_push[i]),
        .pop     (q_pop[i]),
        .din     (enq_desc),
        .head    (q_head[i]),
        .empty   (q_empty[i]),
        .full    (q_full[i])
      );

      assign prio_vec[i*PRI_WIDTH_SIG +: PRI_WIDTH_SIG] = req_vis[i] ? q_head[i].pri : '0;
    end
  endgenerate

`ifdef OQR_BUSY_MASK_EN
  assign req_vis = (state == ST_XFER) ? '0 : req_raw;
`else
  assign req_vis = req_raw;
`endif

  // Burst sequencer: a grant latches the popped head; each accepted beat advances until beat == len.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      base_addr <= '0;
      len_q     <= '0;
      beat      <= '0;
      port_q    <= '0;
    end else if (grant_fire) begin
      state     <= ST_XFER;
      base_addr <= grant_desc.addr;
      len_q     <= grant_desc.len;
      beat      <= '0;
      port_q    <= bus.grant;
    end else if (beat_fire) begin
      if (last_beat) state <= ST_IDLE;
      else           beat  <= beat + LEN_WIDTH'(1);
    end
  end

  assign bus.enq_rdy         = ~q_full[bus.enq_port];
  assign bus.request_signals = req_vis;
  assign bus.priorities      = prio_vec;
  assign bus.rd_vld          = (state == ST_XFER);
  assign bus.rd_addr         = base_addr + ADDR_WIDTH'(beat);
  assign bus.rd_last         = (state == ST_XFER) && last_beat;
  assign bus.rd_port         = port_q;
  assign bus.busy            = (state == ST_XFER);

endmodule

// File: tb/tb_output_queue_requester.sv
// Bench for output_queue_requester: directed scenarios with a read-beat scoreboard.
module tb_output_queue_requester;
  import output_queue_requester_pkg::*;

  localparam int EW = ADDR_WIDTH + 1 + PORT_WIDTH;

  logic clk = 1'b0;
  logic reset_n;

  output_queue_requester_if bus();

  output_queue_requester dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int beat_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_act;

  function automatic logic [EW-1:0] mk(input int addr, input bit last, input int port);
    return {ADDR_WIDTH'(addr), last, PORT_WIDTH'(port)};
  endfunction

  // Scoreboard: every cycle with rd_vld must present the head expected beat; pop on handshake.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.rd_vld === 1'b1) begin
      mon_act = {bus.rd_addr, bus.rd_last, bus.rd_port};
      n_checks++;
      if (exp_q.size() == 0)
        $display("FAIL rd_beat_unexpected: got addr=%h last=%b port=%0d, required no beat",
                 bus.rd_addr, bus.rd_last, bus.rd_port);
      else if (mon_act !== exp_q[0])
        $display("FAIL rd_beat: got {addr,last,port}=%h required %h", mon_act, exp_q[0]);
      else
        n_pass++;
      if (bus.rd_rdy === 1'b1) begin
        beat_cnt++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input int port, input int addr, input int len, input int pri);
    bus.enq_port = PORT_WIDTH'(port);
    bus.enq_addr = ADDR_WIDTH'(addr);
    bus.enq_len  = LEN_WIDTH'(len);
    bus.enq_pri  = PRI_WIDTH_SIG'(pri);
    bus.enq_vld  = 1'b1;
    step();
    bus.enq_vld  = 1'b0;
  endtask

  task automatic do_grant(input int port);
    bus.grant     = PORT_WIDTH'(port);
    bus.grant_vld = 1'b1;
    step();
    bus.grant_vld = 1'b0;
  endtask

  task automatic push_beats(input int port, input int addr, input int len);
    for (int b = 0; b <= len; b++) exp_q.push_back(mk(addr + b, (b == len), port));
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((bus.busy !== 1'b0 || exp_q.size() != 0) && t < 500) begin
      step();
      t++;
    end
    n_checks++;
    if (t >= 500)
      $display("FAIL %s_timeout: busy=%b pending=%0d, required idle with 0 pending",
               name, bus.busy, exp_q.size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.enq_vld   = 1'b0;
    bus.enq_port  = '0;
    bus.enq_addr  = '0;
    bus.enq_len   = '0;
    bus.enq_pri   = '0;
    bus.grant     = '0;
    bus.grant_vld = 1'b0;
    bus.rd_rdy    = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.request_signals !== '0) $display("FAIL reset_req: got %h required 0", bus.request_signals); else n_pass++;
    n_checks++; if (bus.priorities !== '0) $display("FAIL reset_pri: got %h required 0", bus.priorities); else n_pass++;
    n_checks++; if (bus.rd_vld !== 1'b0) $display("FAIL reset_rd_vld: got %b required 0", bus.rd_vld); else n_pass++;
    n_checks++; if (bus.enq_rdy !== 1'b1) $display("FAIL reset_enq_rdy: got %b required 1", bus.enq_rdy); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0 || bus.rd_last !== 1'b0) $display("FAIL reset_busy_last: got %b/%b required 0/0", bus.busy, bus.rd_last); else n_pass++;
    n_checks++; if (bus.rd_addr !== '0 || bus.rd_port !== '0) $display("FAIL reset_addr_port: got %h/%0d required 0/0", bus.rd_addr, bus.rd_port); else n_pass++;
  endtask

  task automatic test_basic();
    logic [PORT_NUB_TOTAL-1:0] exp_req;
    logic [PRI_WIDTH-1:0]      exp_pri;
    exp_req = '0;
    exp_req[3] = 1'b1;
    exp_pri = '0;
    exp_pri[3*PRI_WIDTH_SIG +: PRI_WIDTH_SIG] = PRI_WIDTH_SIG'(5);
    enq(3, 'h100, 2, 5);
    @(negedge clk);
    n_checks++; if (bus.request_signals !== exp_req) $display("FAIL basic_req: got %h required %h", bus.request_signals, exp_req); else n_pass++;
    n_checks++; if (bus.priorities !== exp_pri) $display("FAIL basic_pri: got %h required %h", bus.priorities, exp_pri); else n_pass++;
    exp_q.push_back(mk('h100, 1'b0, 3));
    exp_q.push_back(mk('h101, 1'b0, 3));
    exp_q.push_back(mk('h102, 1'b1, 3));
    do_grant(3);
    @(negedge clk);
    n_checks++; if (bus.rd_vld !== 1'b1 || bus.busy !== 1'b1) $display("FAIL basic_latency: got rd_vld=%b busy=%b required 1/1", bus.rd_vld, bus.busy); else n_pass++;
    n_checks++; if (bus.request_signals[3] !== 1'b0) $display("FAIL basic_req_after_pop: got %b required 0", bus.request_signals[3]); else n_pass++;
    wait_done("basic");
  endtask

  task automatic test_backpressure();
    enq(5, 'h200, 5, 2);
    push_beats(5, 'h200, 5);
    beat_cnt = 0;
    do_grant(5);
    step();
    step();
    bus.rd_rdy = 1'b0;
    repeat (4) step();
    bus.rd_rdy = 1'b1;
    wait_done("backpressure");
    n_checks++; if (beat_cnt !== 6) $display("FAIL backpressure_beats: got %0d required 6", beat_cnt); else n_pass++;
  endtask

  task automatic test_wrap();
    enq(9, 'h3FE, 3, 1);
    exp_q.push_back(mk('h3FE, 1'b0, 9));
    exp_q.push_back(mk('h3FF, 1'b0, 9));
    exp_q.push_back(mk('h000, 1'b0, 9));
    exp_q.push_back(mk('h001, 1'b1, 9));
    do_grant(9);
    wait_done("wrap");
  endtask

  task automatic test_long();
    enq(1, 'h040, 63, 7);
    push_beats(1, 'h040, 63);
    beat_cnt = 0;
    do_grant(1);
    for (int t = 0; t < 1000 && (bus.busy === 1'b1 || exp_q.size() != 0); t++) begin
      bus.rd_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.rd_rdy = 1'b1;
    wait_done("long");
    n_checks++; if (beat_cnt !== 64) $display("FAIL long_beats: got %0d required 64", beat_cnt); else n_pass++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      bus.enq_port = '0;
      bus.enq_addr = ADDR_WIDTH'('h10 + 16 * i);
      bus.enq_len  = '0;
      bus.enq_pri  = PRI_WIDTH_SIG'(7 - i);
      bus.enq_vld  = 1'b1;
      #1;
      n_checks++; if (bus.enq_rdy !== 1'b1) $display("FAIL full_enq_rdy_%0d: got %b required 1", i, bus.enq_rdy); else n_pass++;
      step();
    end
    bus.enq_addr = ADDR_WIDTH'('h3AA);
    #1;
    n_checks++; if (bus.enq_rdy !== 1'b0) $display("FAIL full_enq_rdy_9th: got %b required 0", bus.enq_rdy); else n_pass++;
    step();
    bus.enq_vld = 1'b0;
    n_checks++; if (bus.priorities[PRI_WIDTH_SIG-1:0] !== PRI_WIDTH_SIG'(7)) $display("FAIL full_head_pri: got %0d required 7", bus.priorities[PRI_WIDTH_SIG-1:0]); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk('h10 + 16 * i, 1'b1, 0));
      do_grant(0);
      n_checks++; if (bus.enq_rdy !== 1'b1) $display("FAIL full_enq_rdy_after_pop_%0d: got %b required 1", i, bus.enq_rdy); else n_pass++;
      wait_done("full_drain");
    end
    n_checks++; if (bus.request_signals[0] !== 1'b0) $display("FAIL full_9th_stored: got req=%b required 0", bus.request_signals[0]); else n_pass++;
  endtask

  task automatic test_ignore();
    logic                     exp_req4;
    logic [PRI_WIDTH_SIG-1:0] exp_pri4;
`ifdef OQR_BUSY_MASK_EN
    exp_req4 = 1'b0;
    exp_pri4 = '0;
`else
    exp_req4 = 1'b1;
    exp_pri4 = PRI_WIDTH_SIG'(6);
`endif
    do_grant(7);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.rd_vld !== 1'b0) $display("FAIL ignore_empty: got busy=%b rd_vld=%b required 0/0", bus.busy, bus.rd_vld); else n_pass++;
    // Enqueue and grant to an empty queue in the same cycle: the grant must be dropped.
    bus.enq_port = PORT_WIDTH'(6); bus.enq_addr = ADDR_WIDTH'('h150); bus.enq_len = '0; bus.enq_pri = '0;
    bus.enq_vld = 1'b1;
    do_grant(6);
    bus.enq_vld = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.request_signals[6] !== 1'b1) $display("FAIL ignore_same_cycle: got busy=%b req6=%b required 0/1", bus.busy, bus.request_signals[6]); else n_pass++;
    exp_q.push_back(mk('h150, 1'b1, 6));
    do_grant(6);
    wait_done("same_cycle");
    enq(2, 'h080, 7, 3);
    enq(4, 'h0C0, 1, 6);
    push_beats(2, 'h080, 7);
    do_grant(2);
    do_grant(4);
    @(negedge clk);
    n_checks++; if (bus.request_signals[4] !== exp_req4) $display("FAIL ignore_xfer_req: got %b required %b", bus.request_signals[4], exp_req4); else n_pass++;
    n_checks++; if (bus.priorities[4*PRI_WIDTH_SIG +: PRI_WIDTH_SIG] !== exp_pri4) $display("FAIL ignore_xfer_pri: got %0d required %0d", bus.priorities[4*PRI_WIDTH_SIG +: PRI_WIDTH_SIG], exp_pri4); else n_pass++;
    wait_done("ignore_xfer");
    n_checks++; if (bus.request_signals[4] !== 1'b1) $display("FAIL ignore_req_idle: got %b required 1", bus.request_signals[4]); else n_pass++;
    push_beats(4, 'h0C0, 1);
    do_grant(4);
    wait_done("ignore_drain");
  endtask

  task automatic test_reset_mid_burst();
    enq(11, 'h300, 10, 4);
    enq(12, 'h310, 0, 2);
    push_beats(11, 'h300, 10);
    do_grant(11);
    step();
    #3 reset_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++; if (bus.rd_vld !== 1'b0 || bus.busy !== 1'b0) $display("FAIL midreset_rd_vld: got %b/%b required 0/0", bus.rd_vld, bus.busy); else n_pass++;
    n_checks++; if (bus.request_signals !== '0 || bus.priorities !== '0) $display("FAIL midreset_req: got %h/%h required 0/0", bus.request_signals, bus.priorities); else n_pass++;
    step();
    reset_n = 1'b1;
    step();
    n_checks++; if (bus.rd_vld !== 1'b0 || bus.rd_addr !== '0) $display("FAIL midreset_after: got rd_vld=%b addr=%h required 0/0", bus.rd_vld, bus.rd_addr); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_long();
    test_full();
    test_ignore();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
